// File: rtl/corefifo_gray_ptr_sync.sv
// ---------------------------------------------------------------------------
// corefifo_gray_ptr_sync
//
// Destination-domain synchroniser for a CoreFIFO Gray-coded read or write
// pointer. The foreign-domain pointer passes through a chain of SYNC_STAGES
// flops. It is then converted to binary in one registered stage, which also
// produces a change pulse and the modulo advance since the previous value.
// An optional checker flags Gray steps that flip more than one bit between
// consecutive synchronised samples.
//
// Optional feature macro: COREFIFO_GRAY_CHECK_EN
//   defined   : prev_gray, the multi-bit detector, err_multi and err_sticky
//               are built, and clr_err clears err_sticky.
//   undefined : the checker is absent, err_multi/err_sticky are tied to 0,
//               and clr_err is ignored. All other outputs and latencies are
//               unchanged.
//
// Parameters
//   ADDRWIDTH   : pointer address bits; pointer buses are ADDRWIDTH+1 wide
//                 (the extra bit is the wrap bit).
//   SYNC_STAGES : synchroniser depth, 2..4. Any other value stops elaboration.
//
// Ports
//   clk        in   destination clock; every flop is on the rising edge
//   rstn       in   asynchronous active-low reset
//   inp_gray   in   [ADDRWIDTH:0] Gray pointer from the foreign domain
//   clr_err    in   synchronous clear of err_sticky
//   sync_gray  out  [ADDRWIDTH:0] last synchroniser stage (Gray)
//   sync_bin   out  [ADDRWIDTH:0] registered binary of sync_gray
//   ptr_chg    out  one-cycle pulse when sync_bin changes
//   ptr_delta  out  [ADDRWIDTH:0] (new - previous sync_bin) modulo 2^(ADDRWIDTH+1)
//   err_multi  out  one-cycle pulse on a multi-bit Gray step
//   err_sticky out  latched err_multi
//
// Latency from inp_gray: sync_gray SYNC_STAGES clocks; sync_bin, ptr_chg,
// ptr_delta and err_multi SYNC_STAGES+1 clocks. Every output comes from a
// flop, so no input reaches an output through combinational logic.
// ---------------------------------------------------------------------------
module corefifo_gray_ptr_sync #(
    parameter int ADDRWIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDRWIDTH:0] inp_gray,
    input  logic               clr_err,
    output logic [ADDRWIDTH:0] sync_gray,
    output logic [ADDRWIDTH:0] sync_bin,
    output logic               ptr_chg,
    output logic [ADDRWIDTH:0] ptr_delta,
    output logic               err_multi,
    output logic               err_sticky
);

    localparam int W = ADDRWIDTH + 1;

    // Stop at elaboration on an unsupported synchroniser depth.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $fatal(1, "corefifo_gray_ptr_sync: SYNC_STAGES must be 2..4");
        end
    endgenerate

    // Gray to binary: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // Synchroniser chain
    // -----------------------------------------------------------------------
    logic [W-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= inp_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_gray = stage[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Binary stage with change pulse and modulo advance
    // -----------------------------------------------------------------------
    logic [W-1:0] bin_next;
    logic [W-1:0] delta_next;
    logic [W-1:0] sync_bin_q;
    logic [W-1:0] ptr_delta_q;
    logic         ptr_chg_q;

    // sync_bin_q still holds the binary of the previous sync_gray, so the
    // subtraction is the advance since the last sample. Truncation to W bits
    // makes a wrap (e.g. 15 -> 0) read as a forward step of 1.
    always_comb begin
        bin_next   = gray2bin(sync_gray);
        delta_next = bin_next - sync_bin_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_bin_q  <= '0;
            ptr_delta_q <= '0;
            ptr_chg_q   <= 1'b0;
        end else begin
            sync_bin_q  <= bin_next;
            ptr_delta_q <= delta_next;
            ptr_chg_q   <= (delta_next != '0);
        end
    end

    assign sync_bin  = sync_bin_q;
    assign ptr_delta = ptr_delta_q;
    assign ptr_chg   = ptr_chg_q;

    // -----------------------------------------------------------------------
    // Multi-bit Gray step detector
    // -----------------------------------------------------------------------
`ifdef COREFIFO_GRAY_CHECK_EN
    logic [W-1:0] prev_gray;
    logic [W-1:0] gray_diff;
    logic         err_multi_next;
    logic         err_multi_q;
    logic         err_sticky_q;

    // More than one bit set: nonzero, and clearing the lowest set bit
    // (x & (x-1)) still leaves something.
    always_comb begin
        gray_diff      = sync_gray ^ prev_gray;
        err_multi_next = (gray_diff != '0) &&
                         ((gray_diff & (gray_diff - W'(1))) != '0);
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_gray    <= '0;
            err_multi_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            prev_gray    <= sync_gray;
            err_multi_q  <= err_multi_next;
            err_sticky_q <= err_multi_next | (err_sticky_q & ~clr_err);
        end
    end

    assign err_multi  = err_multi_q;
    assign err_sticky = err_sticky_q;
`else
    // Checker not built: clr_err has no function.
    logic unused_clr_err;
    assign unused_clr_err = clr_err;

    assign err_multi  = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
module tb_corefifo_gray_ptr_sync;

    localparam int AW = 3;
    localparam int W  = AW + 1;

`ifdef COREFIFO_GRAY_CHECK_EN
    localparam logic [W-1:0] EXP_ERR = 1;
`else
    localparam logic [W-1:0] EXP_ERR = 0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] inp_gray = '0;
    logic         clr_err = 1'b0;

    always #5 clk = ~clk;

    logic [W-1:0] sg2, sb2, pd2, sg4, sb4, pd4;
    logic         pc2, em2, es2, pc4, em4, es4;

    corefifo_gray_ptr_sync #(.ADDRWIDTH(AW), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rstn(rstn), .inp_gray(inp_gray), .clr_err(clr_err),
        .sync_gray(sg2), .sync_bin(sb2), .ptr_chg(pc2), .ptr_delta(pd2),
        .err_multi(em2), .err_sticky(es2)
    );

    corefifo_gray_ptr_sync #(.ADDRWIDTH(AW), .SYNC_STAGES(4)) dut4 (
        .clk(clk), .rstn(rstn), .inp_gray(inp_gray), .clr_err(clr_err),
        .sync_gray(sg4), .sync_bin(sb4), .ptr_chg(pc4), .ptr_delta(pd4),
        .err_multi(em4), .err_sticky(es4)
    );

    // ---------------- reference model ----------------
    // hist[k] = inp_gray sampled k rising edges ago (hist[0] = latest edge).
    // Zeros stand in for anything sampled during or before reset.
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] hist[$];
    logic         stk2, stk4;

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary value whose Gray code is g, found by search.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] bv;
        for (int b = 0; b < (1 << W); b++) begin
            bv = W'(b);
            if (b2g(bv) == g) return bv;
        end
        return '0;
    endfunction

    function automatic logic err_of(input int s);
`ifdef COREFIFO_GRAY_CHECK_EN
        return $countones(hist[s] ^ hist[s+1]) > 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic reset_model();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back('0);
        stk2 = 1'b0;
        stk4 = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int s, input string nm,
                             input logic [W-1:0] sg, input logic [W-1:0] sb,
                             input logic [W-1:0] pd, input logic pc,
                             input logic em, input logic es, input logic stk);
        logic [W-1:0] d;
        d = g2b(hist[s]) - g2b(hist[s+1]);
        chk({nm, "_sync_gray"}, sg, hist[s-1]);
        chk({nm, "_sync_bin"}, sb, g2b(hist[s]));
        chk({nm, "_ptr_delta"}, pd, d);
        chk({nm, "_ptr_chg"}, W'(pc), W'(d != '0));
        chk({nm, "_err_multi"}, W'(em), W'(err_of(s)));
        chk({nm, "_err_sticky"}, W'(es), W'(stk));
    endtask

    // ---------------- driver ----------------
    // Apply inputs away from the edge, clock once, update the model, check.
    task automatic cycle(input logic [W-1:0] g, input logic clr);
        inp_gray = g;
        clr_err  = clr;
        @(posedge clk);
        if (!rstn) begin
            reset_model();
        end else begin
            hist.push_front(g);
            void'(hist.pop_back());
            if (err_of(2)) stk2 = 1'b1; else if (clr) stk2 = 1'b0;
            if (err_of(4)) stk4 = 1'b1; else if (clr) stk4 = 1'b0;
        end
        #1;
        check_dut(2, "s2", sg2, sb2, pd2, pc2, em2, es2, stk2);
        check_dut(4, "s4", sg4, sb4, pd4, pc4, em4, es4, stk4);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s2_gray"}, sg2, '0);
        chk({tag, "_s2_bin"}, sb2, '0);
        chk({tag, "_s2_delta"}, pd2, '0);
        chk({tag, "_s2_chg"}, W'(pc2), '0);
        chk({tag, "_s2_em"}, W'(em2), '0);
        chk({tag, "_s2_es"}, W'(es2), '0);
        chk({tag, "_s4_gray"}, sg4, '0);
        chk({tag, "_s4_bin"}, sb4, '0);
        chk({tag, "_s4_delta"}, pd4, '0);
        chk({tag, "_s4_chg"}, W'(pc4), '0);
    endtask

    // ---------------- directed + random sequence ----------------
    logic [W-1:0] cur;
    int           r;

    initial begin
        reset_model();
        rstn = 1'b0;

        // Reset with 0110 on the input, then release.
        cycle(4'b0110, 1'b0);
        cycle(4'b0110, 1'b0);
        check_all_zero("in_reset");
        rstn = 1'b1;
        cycle(4'b0110, 1'b0);
        chk("tp1_gray_clk1", sg2, 4'b0000);
        cycle(4'b0110, 1'b0);
        chk("tp1_gray_clk2", sg2, 4'b0110);
        cycle(4'b0110, 1'b0);
        chk("tp1_bin_clk3", sb2, 4'd4);
        chk("tp1_delta_clk3", pd2, 4'd4);
        chk("tp1_chg_clk3", W'(pc2), 4'd1);
        cycle(4'b0110, 1'b0);
        chk("tp1_chg_clk4", W'(pc2), 4'd0);

        // Walk the Gray sequence 0..15 and back to 0, one code per 4 clocks.
        for (int v = 0; v <= 16; v++) begin
            for (int c = 1; c <= 4; c++) begin
                cycle(b2g(W'(v % 16)), 1'b0);
                if (v >= 1) begin
                    chk("walk_err_multi", W'(em2), 4'd0);
                    if (c == 3) chk("walk_delta", pd2, 4'd1);
                end
            end
        end

        // Depth 4: a single 0000 -> 0001 change.
        for (int c = 0; c < 6; c++) cycle(4'b0000, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cycle(4'b0001, 1'b0);
            chk("s4_gray_lat", sg4, (k >= 4) ? 4'b0001 : 4'b0000);
            chk("s4_bin_lat", sb4, (k >= 5) ? 4'd1 : 4'd0);
        end

        // Illegal jump 0000 -> 0011 (binary 0 -> 2).
        for (int c = 0; c < 6; c++) cycle(4'b0000, 1'b0);
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        chk("jump_delta", pd2, 4'd2);
        chk("jump_err_multi", W'(em2), EXP_ERR);
        chk("jump_err_sticky", W'(es2), EXP_ERR);
        cycle(4'b0011, 1'b0);
        chk("jump_err_multi_off", W'(em2), 4'd0);
        chk("jump_sticky_hold", W'(es2), EXP_ERR);
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);

        // Second illegal jump 0011 -> 0101, clear arriving with the new error.
        cycle(4'b0101, 1'b0);
        cycle(4'b0101, 1'b0);
        cycle(4'b0101, 1'b1);
        chk("clr_vs_set", W'(es2), EXP_ERR);
        cycle(4'b0101, 1'b1);
        chk("clr_alone", W'(es2), 4'd0);
        for (int c = 0; c < 4; c++) cycle(4'b0101, 1'b0);

        // Randomised legal steps, occasional jumps, clears and resets.
        cur = g2b(4'b0101);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r == 6 || r == 7) cur = cur + 1'b1;
            else if (r == 8) cur = cur - 1'b1;
            else if (r == 9) cur = W'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                rstn = 1'b0;
                reset_model();
                cycle(b2g(cur), 1'b0);
                rstn = 1'b1;
            end
            cycle(b2g(cur), ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset while sync_bin = 9.
        for (int c = 0; c < 8; c++) cycle(b2g(4'd9), 1'b0);
        chk("pre_async_bin", sb2, 4'd9);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        reset_model();
        cycle(b2g(4'd9), 1'b0);
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) cycle(b2g(4'd9), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
